// File: rtl/seq_mux_pkg.sv
// Shared FSM encodings, mode constants and a width helper for the seq_mux_scan block.
package seq_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic MODE_MAN  = 1'b0;
  localparam logic MODE_SCAN = 1'b1;

  // Ceiling log2, never less than 1 so single-bit selects and counters stay legal.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mux_nto1.sv
// Combinational N:1 word selector built as a binary tree of 2:1 stages (heap-indexed nodes).
module mux_nto1
  import seq_mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  localparam int SEL_W = clog2(NCH)
) (
  input  logic [NCH*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]     sel,
  output logic [WIDTH-1:0]     dout
);

  localparam int P = 1 << SEL_W;

  // node 0 is the root; node i feeds from 2i+1 (sel bit 0) and 2i+2 (sel bit 1)
  logic [WIDTH-1:0] node [2*P-1];

  for (genvar i = 0; i < P; i++) begin : g_leaf
    if (i < NCH) begin : g_used
      assign node[P-1+i] = din[i*WIDTH +: WIDTH];
    end else begin : g_pad
      assign node[P-1+i] = '0;
    end
  end

  for (genvar i = 0; i < P - 1; i++) begin : g_node
    localparam int DEPTH = $clog2(i + 2) - 1;
    assign node[i] = sel[SEL_W-1-DEPTH] ? node[2*i+2] : node[2*i+1];
  end

  assign dout = node[0];

endmodule

// File: rtl/seq_mux_scan.sv
// Registered N:1 multiplexer with dwell timer, manual/auto-scan channel select and valid/ready output.
// Optional macro SCAN_MASK_EN adds a ch_mask input that removes channels from the scan sequence.
module seq_mux_scan
  import seq_mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int DWELL = 2,
  localparam int SEL_W = clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 mode,
  input  logic [SEL_W-1:0]     sel_in,
  input  logic [NCH*WIDTH-1:0] din,
`ifdef SCAN_MASK_EN
  input  logic [NCH-1:0]       ch_mask,
`endif
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     dout,
  output logic                 out_valid,
  output logic [SEL_W-1:0]     ch_id,
  output logic                 sel_err,
  output logic                 busy
);

  localparam int CNT_W = clog2(DWELL + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] ch_q, ch_d, cur_ch_q, cur_ch_d;
  logic             mode_q, mode_d, err_q, err_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] ch_id_q, ch_id_d;
  logic             sel_err_q, sel_err_d;

  logic [WIDTH-1:0] mux_y;
  logic             ack, go;
  logic [SEL_W-1:0] scan_next, scan_base, lat_scan_ch, lat_ch;
  logic             lat_scan_ok, lat_ok, lat_err;
`ifdef SCAN_MASK_EN
  logic [SEL_W-1:0] scan_idx;
`endif

  mux_nto1 #(.WIDTH(WIDTH), .NCH(NCH)) u_mux (
    .din (din),
    .sel (ch_q),
    .dout(mux_y)
  );

  // Channel for the next sample: scan successor on handshake, then mode/sel_in decide.
  always_comb begin
    ack = (state_q == ST_HOLD) && out_ready;
`ifdef SCAN_MASK_EN
    scan_idx  = '0;
    scan_next = ch_q;
    for (int i = NCH; i >= 1; i--) begin
      scan_idx = SEL_W'((int'(ch_q) + i) % NCH);
      if (ch_mask[scan_idx]) scan_next = scan_idx;
    end
    scan_base   = (ack && mode_q == MODE_SCAN) ? scan_next : cur_ch_q;
    lat_scan_ch = scan_base;
    lat_scan_ok = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      scan_idx = SEL_W'((int'(scan_base) + i) % NCH);
      if (ch_mask[scan_idx]) begin
        lat_scan_ch = scan_idx;
        lat_scan_ok = 1'b1;
      end
    end
`else
    scan_next   = (ch_q == SEL_W'(NCH - 1)) ? '0 : ch_q + SEL_W'(1);
    scan_base   = (ack && mode_q == MODE_SCAN) ? scan_next : cur_ch_q;
    lat_scan_ch = scan_base;
    lat_scan_ok = 1'b1;
`endif
    if (mode == MODE_MAN) begin
      lat_err = (int'(sel_in) >= NCH);
      lat_ch  = lat_err ? '0 : sel_in;
      lat_ok  = 1'b1;
    end else begin
      lat_err = 1'b0;
      lat_ch  = lat_scan_ch;
      lat_ok  = lat_scan_ok;
    end
    go = en && lat_ok;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ch_d        = ch_q;
    mode_d      = mode_q;
    err_d       = err_q;
    cur_ch_d    = cur_ch_q;
    dout_d      = dout_q;
    out_valid_d = out_valid_q;
    ch_id_d     = ch_id_q;
    sel_err_d   = sel_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d = ST_DWELL;
          cnt_d   = '0;
          ch_d    = lat_ch;
          mode_d  = mode;
          err_d   = lat_err;
        end
      end
      ST_DWELL: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = ST_HOLD;
          dout_d      = mux_y;
          ch_id_d     = ch_q;
          sel_err_d   = err_q;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (mode_q == MODE_SCAN) cur_ch_d = scan_next;
          if (go) begin
            state_d = ST_DWELL;
            cnt_d   = '0;
            ch_d    = lat_ch;
            mode_d  = mode;
            err_d   = lat_err;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ch_q        <= '0;
      mode_q      <= MODE_MAN;
      err_q       <= 1'b0;
      cur_ch_q    <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
      ch_id_q     <= '0;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ch_q        <= ch_d;
      mode_q      <= mode_d;
      err_q       <= err_d;
      cur_ch_q    <= cur_ch_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
      ch_id_q     <= ch_id_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign dout      = dout_q;
  assign out_valid = out_valid_q;
  assign ch_id     = ch_id_q;
  assign sel_err   = sel_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_seq_mux_scan.sv
// Self-checking bench for seq_mux_scan: directed scenarios plus a randomized sample-level reference model.
module tb_seq_mux_scan;

  localparam int DWELL = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        en, mode, out_ready;
  logic [1:0]  sel_in;
  logic [31:0] din;
  logic [7:0]  dout;
  logic        out_valid, sel_err, busy;
  logic [1:0]  ch_id;

  logic        en6, mode6, rdy6;
  logic [2:0]  sel6;
  logic [47:0] din6;
  logic [7:0]  dout6;
  logic        ov6, err6, busy6;
  logic [2:0]  ch6;
`ifdef SCAN_MASK_EN
  logic [3:0]  ch_mask;
  logic [5:0]  ch_mask6;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_mux_scan #(.WIDTH(8), .NCH(4), .DWELL(DWELL)) u_dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .sel_in(sel_in), .din(din),
`ifdef SCAN_MASK_EN
    .ch_mask(ch_mask),
`endif
    .out_ready(out_ready), .dout(dout), .out_valid(out_valid), .ch_id(ch_id),
    .sel_err(sel_err), .busy(busy)
  );

  seq_mux_scan #(.WIDTH(8), .NCH(6), .DWELL(DWELL)) u_dut6 (
    .clk(clk), .reset(reset), .en(en6), .mode(mode6), .sel_in(sel6), .din(din6),
`ifdef SCAN_MASK_EN
    .ch_mask(ch_mask6),
`endif
    .out_ready(rdy6), .dout(dout6), .out_valid(ov6), .ch_id(ch6),
    .sel_err(err6), .busy(busy6)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en = 1'b0; mode = 1'b0; out_ready = 1'b0; sel_in = '0; din = '0;
    en6 = 1'b0; mode6 = 1'b0; rdy6 = 1'b0; sel6 = '0; din6 = '0;
`ifdef SCAN_MASK_EN
    ch_mask = '1; ch_mask6 = '1;
`endif
    step(); step();
    reset = 1'b0;
    step();
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int k;
    k = 0;
    while (!out_valid && k < budget) begin
      step();
      k++;
    end
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_timeout: out_valid=%0b after %0d cycles, required 1", tag, out_valid, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    en = 1'b0; mode = 1'b0; out_ready = 1'b0; sel_in = '0; din = '0;
    en6 = 1'b0; mode6 = 1'b0; rdy6 = 1'b0; sel6 = '0; din6 = '0;
`ifdef SCAN_MASK_EN
    ch_mask = '1; ch_mask6 = '1;
`endif
    #2;
    n_tests++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %0h required 0", dout); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b required 0", out_valid); end
    n_tests++; if (ch_id !== 2'd0) begin n_fail++; $display("FAIL reset_ch_id: got %0d required 0", ch_id); end
    n_tests++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL reset_sel_err: got %0b required 0", sel_err); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b required 0", busy); end
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_manual();
    do_reset();
    mode = 1'b0; sel_in = 2'd2; din = {8'h3C, 8'hA5, 8'h5A, 8'h11}; out_ready = 1'b0; en = 1'b1;
    step();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL manual_busy: got %0b required 1", busy); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL manual_early1: got %0b required 0", out_valid); end
    mode = 1'b1; sel_in = 2'd0;
    step();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL manual_early2: got %0b required 0", out_valid); end
    step();
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL manual_valid: got %0b required 1", out_valid); end
    n_tests++; if (dout !== 8'hA5) begin n_fail++; $display("FAIL manual_dout: got %0h required a5", dout); end
    n_tests++; if (ch_id !== 2'd2) begin n_fail++; $display("FAIL manual_ch_id: got %0d required 2", ch_id); end
    n_tests++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL manual_sel_err: got %0b required 0", sel_err); end
    en = 1'b0; out_ready = 1'b1;
    step();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL manual_ack_valid: got %0b required 0", out_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL manual_ack_busy: got %0b required 0", busy); end
    out_ready = 1'b0;
  endtask

  task automatic test_scan_wrap();
    int vedge[$];
    logic [7:0] vd[$];
    do_reset();
    mode = 1'b1; din = {8'h13, 8'h12, 8'h11, 8'h10}; out_ready = 1'b1; en = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      step();
      if (out_valid) begin
        vedge.push_back(c);
        vd.push_back(dout);
      end
    end
    n_tests++;
    if (vd.size() < 5) begin
      n_fail++;
      $display("FAIL scan_count: got %0d samples required at least 5", vd.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_tests++;
        if (vd[k] !== 8'(8'h10 + (k % 4))) begin
          n_fail++; $display("FAIL scan_dout%0d: got %0h required %0h", k, vd[k], 8'h10 + (k % 4));
        end
        n_tests++;
        if (vedge[k] != 1 + DWELL + k * (DWELL + 1)) begin
          n_fail++; $display("FAIL scan_time%0d: got cycle %0d required %0d", k, vedge[k], 1 + DWELL + k * (DWELL + 1));
        end
      end
    end
    en = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0] d0;
    logic [1:0] c0;
    do_reset();
    mode = 1'b1; din = {8'h13, 8'h12, 8'h11, 8'h10}; out_ready = 1'b0; en = 1'b1;
    wait_valid(10, "bp_first");
    d0 = dout; c0 = ch_id;
    n_tests++; if (d0 !== 8'h10) begin n_fail++; $display("FAIL bp_first_dout: got %0h required 10", d0); end
    n_tests++; if (c0 !== 2'd0) begin n_fail++; $display("FAIL bp_first_ch: got %0d required 0", c0); end
    for (int k = 0; k < 5; k++) begin
      din = $urandom;
      mode = 1'($urandom_range(0, 1));
      step();
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid%0d: got %0b required 1", k, out_valid); end
      n_tests++; if (dout !== d0) begin n_fail++; $display("FAIL bp_hold_dout%0d: got %0h required %0h", k, dout, d0); end
      n_tests++; if (ch_id !== c0) begin n_fail++; $display("FAIL bp_hold_ch%0d: got %0d required %0d", k, ch_id, c0); end
    end
    mode = 1'b1; din = {8'h13, 8'h12, 8'h11, 8'h10}; out_ready = 1'b1;
    step();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_ack: got %0b required 0", out_valid); end
    out_ready = 1'b0;
    wait_valid(10, "bp_second");
    n_tests++; if (ch_id !== 2'd1) begin n_fail++; $display("FAIL bp_next_ch: got %0d required 1", ch_id); end
    n_tests++; if (dout !== 8'h11) begin n_fail++; $display("FAIL bp_next_dout: got %0h required 11", dout); end
    en = 1'b0; out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_abort();
    do_reset();
    mode = 1'b1; din = {8'h13, 8'h12, 8'h11, 8'h10}; out_ready = 1'b0; en = 1'b1;
    wait_valid(10, "abort_first");
    en = 1'b0; out_ready = 1'b1;
    step();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle_after_ack: got %0b required 0", busy); end
    out_ready = 1'b0; en = 1'b1;
    step();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_dwell_busy: got %0b required 1", busy); end
    en = 1'b0;
    step();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %0b required 0", busy); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %0b required 0", out_valid); end
    step();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid_late: got %0b required 0", out_valid); end
    en = 1'b1;
    wait_valid(10, "abort_resume");
    n_tests++; if (ch_id !== 2'd1) begin n_fail++; $display("FAIL abort_cur_ch: got %0d required 1", ch_id); end
    en = 1'b0; out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    mode = 1'b1; din = {8'h13, 8'h12, 8'h11, 8'h10}; out_ready = 1'b0; en = 1'b1;
    wait_valid(10, "rst_first");
    out_ready = 1'b1; step(); out_ready = 1'b0;
    wait_valid(10, "rst_second");
    #3;
    reset = 1'b1;
    #1;
    n_tests++; if (dout !== 8'h00) begin n_fail++; $display("FAIL rst_hold_dout: got %0h required 0", dout); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_hold_valid: got %0b required 0", out_valid); end
    n_tests++; if (ch_id !== 2'd0) begin n_fail++; $display("FAIL rst_hold_ch: got %0d required 0", ch_id); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_hold_busy: got %0b required 0", busy); end
    step();
    reset = 1'b0; en = 1'b0;
    step();
  endtask

  task automatic test_sel_err();
    do_reset();
    for (int k = 0; k < 6; k++) din6[k*8 +: 8] = 8'(8'h60 + k);
    mode6 = 1'b0; sel6 = 3'd7; rdy6 = 1'b0; en6 = 1'b1;
    step(); step(); step();
    n_tests++; if (ov6 !== 1'b1) begin n_fail++; $display("FAIL err_valid: got %0b required 1", ov6); end
    n_tests++; if (err6 !== 1'b1) begin n_fail++; $display("FAIL err_flag: got %0b required 1", err6); end
    n_tests++; if (ch6 !== 3'd0) begin n_fail++; $display("FAIL err_ch: got %0d required 0", ch6); end
    n_tests++; if (dout6 !== 8'h60) begin n_fail++; $display("FAIL err_dout: got %0h required 60", dout6); end
    rdy6 = 1'b1; sel6 = 3'd5;
    step();
    rdy6 = 1'b0;
    step(); step();
    n_tests++; if (ov6 !== 1'b1) begin n_fail++; $display("FAIL ok_valid: got %0b required 1", ov6); end
    n_tests++; if (err6 !== 1'b0) begin n_fail++; $display("FAIL ok_flag: got %0b required 0", err6); end
    n_tests++; if (ch6 !== 3'd5) begin n_fail++; $display("FAIL ok_ch: got %0d required 5", ch6); end
    n_tests++; if (dout6 !== 8'h65) begin n_fail++; $display("FAIL ok_dout: got %0h required 65", dout6); end
    en6 = 1'b0; rdy6 = 1'b1; step(); rdy6 = 1'b0;
  endtask

`ifdef SCAN_MASK_EN
  task automatic test_mask();
    logic [1:0] seen[$];
    int exp_seq[4] = '{1, 3, 1, 3};
    do_reset();
    ch_mask = 4'b1010; mode = 1'b1; din = {8'h13, 8'h12, 8'h11, 8'h10}; out_ready = 1'b1; en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (out_valid) seen.push_back(ch_id);
    end
    n_tests++;
    if (seen.size() < 4) begin
      n_fail++; $display("FAIL mask_count: got %0d samples required at least 4", seen.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_tests++;
        if (int'(seen[k]) != exp_seq[k]) begin
          n_fail++; $display("FAIL mask_ch%0d: got %0d required %0d", k, seen[k], exp_seq[k]);
        end
      end
    end
    do_reset();
    ch_mask = 4'b0000; mode = 1'b1; en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mask_none_busy%0d: got %0b required 0", c, busy); end
    end
    en = 1'b0;
  endtask
`endif

  // Sample-level model: a sample is bound at its start edge, captured DWELL edges later,
  // held until a ready edge, and the next sample starts on that same edge while en stays high.
  task automatic test_random();
    int scan_ptr, cap_edge, cur_ch;
    bit holding, need_latch, exp_scan;
    logic [7:0] exp_d;
    do_reset();
    scan_ptr = 0; cap_edge = -1; cur_ch = 0; holding = 0; need_latch = 1; exp_scan = 0; exp_d = '0;
    en = 1'b1;
    for (int e = 0; e < 300; e++) begin
      mode      = 1'($urandom_range(0, 1));
      sel_in    = 2'($urandom_range(0, 3));
      din       = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      if (holding && out_ready) begin
        holding = 0;
        if (exp_scan) scan_ptr = (cur_ch + 1) % 4;
        need_latch = 1;
      end else if (!holding && !need_latch && e == cap_edge) begin
        holding = 1;
        exp_d   = din[cur_ch*8 +: 8];
      end
      if (need_latch) begin
        need_latch = 0;
        exp_scan   = mode;
        cur_ch     = mode ? scan_ptr : int'(sel_in);
        cap_edge   = e + DWELL;
      end
      step();
      n_tests++;
      if (out_valid !== holding) begin
        n_fail++; $display("FAIL rnd_valid@%0d: got %0b required %0b", e, out_valid, holding);
      end
      if (holding) begin
        n_tests++;
        if (dout !== exp_d) begin n_fail++; $display("FAIL rnd_dout@%0d: got %0h required %0h", e, dout, exp_d); end
        n_tests++;
        if (int'(ch_id) != cur_ch) begin n_fail++; $display("FAIL rnd_ch@%0d: got %0d required %0d", e, ch_id, cur_ch); end
        n_tests++;
        if (sel_err !== 1'b0) begin n_fail++; $display("FAIL rnd_sel_err@%0d: got %0b required 0", e, sel_err); end
      end
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_manual();
    test_scan_wrap();
    test_backpressure();
    test_abort();
    test_reset_mid_hold();
    test_sel_err();
`ifdef SCAN_MASK_EN
    test_mask();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
